// File: rtl/multicycle_control.sv
// multicycle_control
//
// Multi-cycle control FSM for the MIPS datapath. Each instruction walks
// FETCH -> DECODE -> (execute / memory / writeback states) -> FETCH. In every
// state the FSM drives the shared-datapath mux selects and enables.
//
// Memory handshake: the FSM holds a memory request (FETCH, MEMRD or MEMWR)
// and stays in that state. When mem_ready is 1 during a cycle, the access
// completes at the next rising edge. There is no separate request-valid
// signal, because being in one of those states is the request.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode, funct     instruction register fields [31:26] and [5:0]
//   mem_ready         memory finishes the current access this cycle
//   pc_write .. alu_src_a, reg_dst, alu_src_b, alu_op, pc_src, branch_ne
//                     datapath controls, decoded from the state register
//   bus_err, ill_op   sticky error flags (memory timeout, illegal opcode)
//   state_o           current state encoding
//   retired           completed-instruction counter (wraps)
//
// Configuration: defining MULTICYCLE_CTRL_BNE_EN enables bne (opcode 000101).
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       reg_dst,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             branch_ne,
    output logic             bus_err,
    output logic             ill_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_IMMEX  = 4'd8,  S_IMMWB  = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_ERROR  = 4'd15
    } state_t;

    // The wait counter never passes WAIT_LIMIT-1: the next not-ready cycle
    // either ends in ERROR or the counter clears.
    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    // Sub-class flags are captured in DECODE. Later states then depend only
    // on registered values, not on the instruction-register inputs.
    logic              is_store_q, is_store_d;
    logic              imm_logic_q, imm_logic_d;
`ifdef MULTICYCLE_CTRL_BNE_EN
    logic              bne_q, bne_d;
`endif
    logic              retire, set_bus_err, set_ill_op, timeout;

    // This cycle would be the WAIT_LIMIT-th consecutive not-ready cycle.
    assign timeout = (WAIT_LIMIT != 0) && !mem_ready && (wait_q == WAIT_LAST);
    assign state_o = state_q;

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        is_store_d    = is_store_q;
        imm_logic_d   = imm_logic_q;
`ifdef MULTICYCLE_CTRL_BNE_EN
        bne_d         = bne_q;
`endif
        retire        = 1'b0;
        set_bus_err   = 1'b0;
        set_ill_op    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = 2'b00;
        pc_src        = 2'd0;
        branch_ne     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d     = S_ERROR;
                    set_bus_err = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    6'b000000: state_d = (funct == 6'b001000) ? S_JR : S_EXEC;
                    6'b100011: begin state_d = S_MEMADR; is_store_d = 1'b0; end
                    6'b101011: begin state_d = S_MEMADR; is_store_d = 1'b1; end
                    6'b001000: begin state_d = S_IMMEX; imm_logic_d = 1'b0; end
                    6'b001100,
                    6'b001101: begin state_d = S_IMMEX; imm_logic_d = 1'b1; end
`ifdef MULTICYCLE_CTRL_BNE_EN
                    6'b000100: begin state_d = S_BRANCH; bne_d = 1'b0; end
                    6'b000101: begin state_d = S_BRANCH; bne_d = 1'b1; end
`else
                    6'b000100: state_d = S_BRANCH;
`endif
                    6'b000010: state_d = S_JUMP;
                    6'b000011: state_d = S_JAL;
                    default: begin
                        state_d    = S_ERROR;
                        set_ill_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = is_store_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_read  = (state_q == S_MEMRD);
                mem_write = (state_q == S_MEMWR);
                if (mem_ready) begin
                    if (state_q == S_MEMRD) begin
                        state_d = S_MEMWB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = S_ERROR;
                    set_bus_err = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = imm_logic_q ? 2'b11 : 2'b00;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
`ifdef MULTICYCLE_CTRL_BNE_EN
                branch_ne     = bne_q;
`endif
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_JAL: begin
                // mem_to_reg stays 0; the datapath routes the PC as write data.
                pc_write  = 1'b1;
                pc_src    = 2'd2;
                reg_write = 1'b1;
                reg_dst   = 2'd2;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'd3;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            is_store_q  <= 1'b0;
            imm_logic_q <= 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
            bne_q       <= 1'b0;
`endif
            retired     <= '0;
            bus_err     <= 1'b0;
            ill_op      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            is_store_q  <= is_store_d;
            imm_logic_q <= imm_logic_d;
`ifdef MULTICYCLE_CTRL_BNE_EN
            bne_q       <= bne_d;
`endif
            if (retire)      retired <= retired + CNT_W'(1);
            if (set_bus_err) bus_err <= 1'b1;
            if (set_ill_op)  ill_op  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into the cycle-by-cycle state sequence implied by its class and chosen
// memory wait counts. The expected controls for each state come from the
// per-state control table.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    // State encodings
    localparam int FETCH = 0,  DECODE = 1,  MEMADR = 2,  MEMRD = 3,  MEMWB = 4;
    localparam int MEMWR = 5,  EXEC = 6,    ALUWB = 7,   IMMEX = 8,  IMMWB = 9;
    localparam int BRANCH = 10, JUMP = 11,  JAL = 12,    JR = 13,    ERR = 15;

    // Instruction classes used by the stimulus generator
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_ADDI = 3, C_ANDI = 4, C_ORI = 5;
    localparam int C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_BNE = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic             mem_to_reg, reg_write, alu_src_a, branch_ne, bus_err, ill_op;
    logic [1:0]       reg_dst, alu_src_b, alu_op, pc_src;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int   exp_ret = 0;
    logic exp_bus = 1'b0;
    logic exp_ill = 1'b0;
    logic cur_li  = 1'b0;   // current instruction is andi/ori
    logic cur_ne  = 1'b0;   // current instruction is bne

    multicycle_control #(.WAIT_LIMIT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .reg_dst(reg_dst), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .branch_ne(branch_ne),
        .bus_err(bus_err), .ill_op(ill_op), .state_o(state_o), .retired(retired)
    );

    // Clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] pack_dut();
        return {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                mem_to_reg, reg_write, alu_src_a, reg_dst, alu_src_b, alu_op,
                pc_src, branch_ne};
    endfunction

    // Per-state control table
    function automatic logic [17:0] exp_ctrl(input int st, input logic rdy,
                                             input logic li, input logic ne);
        logic pw = 0, pwc = 0, irw = 0, iod = 0, mr = 0, mw = 0, m2r = 0, rw = 0, sa = 0, bn = 0;
        logic [1:0] rd = 0, sb = 0, op = 0, ps = 0;
        case (st)
            FETCH:  begin mr = 1; sb = 1; irw = rdy; pw = rdy; end
            DECODE: sb = 3;
            MEMADR: begin sa = 1; sb = 2; end
            MEMRD:  begin mr = 1; iod = 1; end
            MEMWR:  begin mw = 1; iod = 1; end
            MEMWB:  begin rw = 1; m2r = 1; end
            EXEC:   begin sa = 1; op = 2; end
            ALUWB:  begin rw = 1; rd = 1; end
            IMMEX:  begin sa = 1; sb = 2; op = li ? 2'd3 : 2'd0; end
            IMMWB:  rw = 1;
            BRANCH: begin sa = 1; op = 1; pwc = 1; ps = 1; bn = ne; end
            JUMP:   begin pw = 1; ps = 2; end
            JAL:    begin pw = 1; ps = 2; rw = 1; rd = 2; end
            JR:     begin pw = 1; ps = 3; end
            default: ;
        endcase
        return {pw, pwc, irw, iod, mr, mw, m2r, rw, sa, rd, sb, op, ps, bn};
    endfunction

    // Driver tasks. Entry point for step is always just after a rising edge.
    task automatic step(input int st, input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
        check("state",   64'(state_o), 64'(st));
        check("ctrl",    64'(pack_dut()), 64'(exp_ctrl(st, rdy, cur_li, cur_ne)));
        check("retired", 64'(retired), 64'(exp_ret));
        check("bus_err", 64'(bus_err), 64'(exp_bus));
        check("ill_op",  64'(ill_op),  64'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        exp_ret = 0;
        exp_bus = 1'b0;
        exp_ill = 1'b0;
        #2;  // asynchronous: no clock edge has occurred yet
        check("rst_state",   64'(state_o), 64'(FETCH));
        check("rst_ctrl",    64'(pack_dut()), 64'(exp_ctrl(FETCH, 1'b0, 1'b0, 1'b0)));
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_flags",   64'({bus_err, ill_op}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic mem_phase(input int st, input int waits);
        for (int i = 0; i < waits; i++) step(st, 1'b0);
        step(st, 1'b1);
    endtask

    task automatic run_instr(input int cls, input int wf, input int wm);
        logic [5:0] fn;
        fn = 6'($urandom_range(0, 63));
        cur_li = 1'b0;
        cur_ne = 1'b0;
        case (cls)
            C_R:    begin opcode = 6'b000000; while (fn == 6'b001000) fn = 6'($urandom_range(0, 63)); end
            C_LW:   opcode = 6'b100011;
            C_SW:   opcode = 6'b101011;
            C_ADDI: opcode = 6'b001000;
            C_ANDI: begin opcode = 6'b001100; cur_li = 1'b1; end
            C_ORI:  begin opcode = 6'b001101; cur_li = 1'b1; end
            C_BEQ:  opcode = 6'b000100;
            C_J:    opcode = 6'b000010;
            C_JAL:  opcode = 6'b000011;
            C_JR:   begin opcode = 6'b000000; fn = 6'b001000; end
            default: begin opcode = 6'b000101; cur_ne = 1'b1; end
        endcase
        funct = fn;
        mem_phase(FETCH, wf);
        step(DECODE, rnd_bit());
        case (cls)
            C_R:    begin step(EXEC, rnd_bit()); step(ALUWB, rnd_bit()); end
            C_LW:   begin step(MEMADR, rnd_bit()); mem_phase(MEMRD, wm); step(MEMWB, rnd_bit()); end
            C_SW:   begin step(MEMADR, rnd_bit()); mem_phase(MEMWR, wm); end
            C_ADDI, C_ANDI, C_ORI: begin step(IMMEX, rnd_bit()); step(IMMWB, rnd_bit()); end
            C_J:    step(JUMP, rnd_bit());
            C_JAL:  step(JAL, rnd_bit());
            C_JR:   step(JR, rnd_bit());
            default: step(BRANCH, rnd_bit());  // beq / bne
        endcase
        exp_ret++;
    endtask

    function automatic int rnd_wait();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 3));
    endfunction

    // Main sequence
    initial begin
        int max_cls;
`ifdef MULTICYCLE_CTRL_BNE_EN
        max_cls = C_BNE;
`else
        max_cls = C_JR;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // add with zero waits, then lw with three not-ready MEMRD cycles
        run_instr(C_R, 0, 0);
        run_instr(C_LW, 0, 3);
        run_instr(C_JAL, 0, 0);
        run_instr(C_JR, 0, 0);
        // mem_ready arriving exactly on the 15th fetch cycle: no error
        run_instr(C_SW, 14, 14);

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, max_cls)), rnd_wait(), rnd_wait());
        end

        // Fetch timeout: 15 consecutive not-ready cycles -> ERROR, bus_err
        do_reset();
        for (int i = 0; i < 15; i++) step(FETCH, 1'b0);
        exp_bus = 1'b1;
        for (int i = 0; i < 4; i++) step(ERR, rnd_bit());

        // Memory-read timeout
        do_reset();
        opcode = 6'b100011;
        step(FETCH, 1'b1);
        step(DECODE, 1'b0);
        step(MEMADR, 1'b0);
        for (int i = 0; i < 15; i++) step(MEMRD, 1'b0);
        exp_bus = 1'b1;
        step(ERR, 1'b1);
        step(ERR, 1'b0);

        // Illegal opcode: ERROR is absorbing until reset
        do_reset();
        run_instr(C_ADDI, 1, 0);
        opcode = 6'b111111;
        step(FETCH, 1'b1);
        step(DECODE, 1'b1);
        exp_ill = 1'b1;
        for (int i = 0; i < 5; i++) step(ERR, rnd_bit());

        // Asynchronous reset in the middle of a load access
        do_reset();
        run_instr(C_ORI, 0, 0);
        opcode = 6'b100011;
        step(FETCH, 1'b1);
        step(DECODE, 1'b1);
        step(MEMADR, 1'b1);
        step(MEMRD, 1'b0);
        step(MEMRD, 1'b0);
        do_reset();
        run_instr(C_BEQ, 0, 0);

        // Opcode 000101
`ifdef MULTICYCLE_CTRL_BNE_EN
        run_instr(C_BNE, 0, 0);
        run_instr(C_BNE, 2, 0);
`else
        opcode = 6'b000101;
        step(FETCH, 1'b1);
        step(DECODE, 1'b1);
        exp_ill = 1'b1;
        step(ERR, 1'b1);
        step(ERR, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the MIPS RISC processor. It replaces the single-cycle combinational opcode decoder. It steps each instruction through fetch, decode, execute, memory and writeback states and drives the shared-datapath mux selects and enables for each state. It waits on a memory-ready handshake, times out stalled accesses, traps illegal opcodes, and counts retired instructions.

## Interface
- `WAIT_LIMIT`, default 15: consecutive not-ready memory cycles tolerated before a bus error; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `alu_src_a` out 1 each: datapath enables and selects.
- `reg_dst` out 2: write-register select; 0 = rt, 1 = rd, 2 = $31.
- `alu_src_b` out 2: ALU B-input select; 0 = B, 1 = 4, 2 = sign-extended immediate, 3 = immediate << 2.
- `alu_op` out 2: ALU operation class; 00 = add, 01 = sub, 10 = funct, 11 = logical immediate.
- `pc_src` out 2: next-PC select; 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = register A.
- `branch_ne` out 1: invert the zero flag for the branch condition.
- `bus_err` out 1: sticky memory timeout.
- `ill_op` out 1: sticky illegal opcode.
- `state_o` out 4: current state encoding.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, IMMEX 8, IMMWB 9, BRANCH 10, JUMP 11, JAL 12, JR 13, ERROR 15.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=00, `pc_src`=0. `ir_write` and `pc_write` equal `mem_ready`. The FSM stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3 (branch target precompute). Dispatch by opcode:
  - 000000 with funct 001000 → JR; any other funct → EXEC.
  - 100011 or 101011 → MEMADR.
  - 001000 → IMMEX with `alu_op`=00.
  - 001100 or 001101 → IMMEX with `alu_op`=11.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - 000011 → JAL.
  - Any other opcode → ERROR and set `ill_op`.
- MEMADR: `alu_src_a`=1, `alu_src_b`=2. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWR: `mem_write`=1, `i_or_d`=1. Hold until `mem_ready`, then retire and go to FETCH.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=10.
- ALUWB: `reg_write`=1, `reg_dst`=1.
- IMMEX: `alu_src_a`=1, `alu_src_b`=2.
- IMMWB: `reg_write`=1, `reg_dst`=0.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=01, `pc_write_cond`=1, `pc_src`=1.
- JUMP: `pc_write`=1, `pc_src`=2.
- JAL: `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=0. The write data is the PC.
- JR: `pc_write`=1, `pc_src`=3.
- Every terminal state (MEMWB, MEMWR on ready, ALUWB, IMMWB, BRANCH, JUMP, JAL, JR) increments `retired` and returns to FETCH. `retired` wraps modulo 2^CNT_W.
- Wait counter: increments on each cycle in FETCH, MEMRD or MEMWR with `mem_ready`=0, and clears on `mem_ready` or on leaving those states. When it reaches WAIT_LIMIT with `mem_ready` still 0 (WAIT_LIMIT≠0), the FSM goes to ERROR and sets `bus_err`.
- ERROR: all enables are 0. ERROR is absorbing and is left only via `rst_n`.
- Any output not listed for a state is 0.

## Timing
- Outputs are Moore-decoded from the state register. The only exceptions are `ir_write` and `pc_write` in FETCH, which are gated by `mem_ready`.
- Zero-wait latencies in cycles: R-type 4, lw 5, sw 4, addi/andi/ori 4, beq 3, j 3, jal 3, jr 3.
- Each not-ready cycle in a memory state adds one cycle.
- Reset (async assert, at any point including mid-access): state=FETCH, `retired`=0, `bus_err`=0, `ill_op`=0, wait counter=0. Outputs then show the FETCH values: `mem_read`=1, `alu_src_b`=1, everything else 0.
- Reset deassertion takes effect at the next rising edge.
- `mem_ready` arriving on the same cycle the counter reaches WAIT_LIMIT counts as completion; no error is raised.

## Configuration
- `MULTICYCLE_CTRL_BNE_EN` defined: opcode 000101 dispatches to BRANCH with `branch_ne`=1. bne takes 3 cycles and retires like beq.
- `MULTICYCLE_CTRL_BNE_EN` undefined: opcode 000101 is illegal (ERROR, `ill_op`=1), and `branch_ne` is tied to 0.

## Test plan
- add (op 000000, funct 100000), `mem_ready` held 1 → states 0,1,6,7,0. `reg_write`=1 with `reg_dst`=1 in cycle 4; `retired` goes 0→1.
- lw with `mem_ready` low for 3 cycles in MEMRD → 8 cycles total, `mem_read`=1 and `i_or_d`=1 throughout MEMRD, then MEMWB asserts `reg_write` and `mem_to_reg`.
- WAIT_LIMIT=15, `mem_ready`=0 held in FETCH → ERROR (state_o=15) after 15 cycles with `bus_err`=1. `mem_ready`=1 exactly on cycle 15 → DECODE instead, no error.
- opcode 111111 → ERROR at the 3rd edge, `ill_op`=1, all enables 0 until `rst_n` pulses low, then FETCH with `retired`=0.
- jal then jr (funct 001000) → each takes 3 cycles. JAL asserts `reg_dst`=2, `pc_src`=2, `reg_write`=1; JR asserts `pc_src`=3.
- opcode 000101 → with the macro: BRANCH with `branch_ne`=1 and `pc_write_cond`=1; without the macro: ERROR with `ill_op`=1.
